// File: rtl/image_readout_streamer_pkg.sv
// Shared types and constants for the image readout streamer.
// The checksum width is used only when READOUT_CHECKSUM_EN is defined.
package image_readout_pkg;
   localparam int unsigned DEFAULT_ADDR_WIDTH = 16;
   localparam int unsigned CHECKSUM_WIDTH     = 16;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_READY = 3'd1,
      ST_STREAM     = 3'd2,
      ST_DRAIN      = 3'd3,
      ST_DONE       = 3'd4
   } state_t;
endpackage

// File: rtl/image_readout_streamer_if.sv
// Buffer read port plus outbound byte stream of the image readout streamer.
interface image_readout_streamer_if import image_readout_pkg::*; #(
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();
   logic [ADDR_WIDTH-1:0] buffer_address_out;
   logic                  buffer_address_valid_out;
   logic [7:0]            buffer_data_in;
   logic [7:0]            byte_out;
   logic                  byte_valid_out;
   logic                  byte_ready_in;

   modport master (
      output buffer_address_out, buffer_address_valid_out, byte_out, byte_valid_out,
      input  buffer_data_in, byte_ready_in
   );

   modport slave (
      input  buffer_address_out, buffer_address_valid_out, byte_out, byte_valid_out,
      output buffer_data_in, byte_ready_in
   );
endinterface

// File: rtl/image_readout_streamer_readout_fifo.sv
// Prefetch FIFO with a registered head entry, occupancy count and flush.
module readout_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_valid,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic [CW-1:0]    r_mem_count;
   logic [WIDTH-1:0] r_head;
   logic             r_head_valid;

   logic w_head_load;
   logic w_from_mem;
   logic w_bypass;
   logic w_mem_write;

   // Head refills from storage first; an empty FIFO forwards the push straight to the head.
   assign w_head_load = !r_head_valid || i_pop;
   assign w_from_mem  = w_head_load && (r_mem_count != '0);
   assign w_bypass    = w_head_load && (r_mem_count == '0) && i_push;
   assign w_mem_write = i_push && !w_bypass;

   always_ff @(posedge i_clk) begin
      if (w_mem_write) r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wr         <= '0;
         r_rd         <= '0;
         r_mem_count  <= '0;
         r_head       <= '0;
         r_head_valid <= 1'b0;
      end else begin
         if (w_mem_write) r_wr <= r_wr + PW'(1);
         if (w_from_mem) begin
            r_head <= r_mem[r_rd];
            r_rd   <= r_rd + PW'(1);
         end else if (w_bypass) begin
            r_head <= i_data;
         end
         if (w_head_load) r_head_valid <= w_from_mem || w_bypass;
         r_mem_count <= r_mem_count + CW'(w_mem_write) - CW'(w_from_mem);
      end
   end

   assign o_data  = r_head;
   assign o_valid = r_head_valid;
   assign o_count = r_mem_count + CW'(r_head_valid);
endmodule

// File: rtl/image_readout_streamer.sv
// Streams a finished JPEG image out of the image buffer with read prefetch.
// Optional READOUT_CHECKSUM_EN adds checksum_out (sum of delivered bytes mod 2^16).
module image_readout_streamer import image_readout_pkg::*; #(
   parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                      clock_in,
   input  logic                      reset_in,
   input  logic                      start_in,
   input  logic                      image_ready_in,
   input  logic [ADDR_WIDTH-1:0]     image_size_in,
   image_readout_streamer_if.master  bus,
   output logic                      busy_out,
   output logic                      done_out,
   output logic                      error_out,
   output logic [ADDR_WIDTH-1:0]     bytes_remaining_out
`ifdef READOUT_CHECKSUM_EN
   ,
   output logic [CHECKSUM_WIDTH-1:0] checksum_out
`endif
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   state_t                  r_state, w_state_next;
   logic [ADDR_WIDTH-1:0]   r_size, r_issued, r_delivered, r_remaining, r_addr;
   logic [CW-1:0]           r_outstanding;
   logic [READ_LATENCY-1:0] r_pipe;
   logic                    r_addr_valid, r_busy, r_done, r_error;
   logic                    w_busy_next, w_done_next, w_error_next;
   logic                    w_start_ok, w_abort, w_pop, w_push, w_issue, w_credit_ok;
   logic [CW-1:0]           w_fifo_count;
   logic [CW:0]             w_credit_sum;
   logic [7:0]              w_fifo_data;
   logic                    w_fifo_valid;
   logic [ADDR_WIDTH-1:0]   w_delivered_next;

   assign w_start_ok       = start_in && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_abort          = !image_ready_in && (r_state == ST_STREAM || r_state == ST_DRAIN);
   assign w_pop            = w_fifo_valid && bus.byte_ready_in;
   assign w_push           = r_pipe[READ_LATENCY-1];
   assign w_delivered_next = r_delivered + ADDR_WIDTH'(w_pop);

   // A pop frees its slot in the same cycle, so the consumer sees one byte per cycle.
   assign w_credit_sum = (CW+1)'(w_fifo_count) + (CW+1)'(r_outstanding) - (CW+1)'(w_pop);
   assign w_credit_ok  = w_credit_sum < (CW+1)'(FIFO_DEPTH);
   // Issuing on the WAIT_READY exit makes the first strobe coincide with the first STREAM cycle.
   assign w_issue = image_ready_in && (r_state == ST_WAIT_READY || r_state == ST_STREAM)
                    && (r_issued < r_size) && w_credit_ok;

   always_ff @(posedge clock_in) begin
      if (reset_in) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:       if (w_start_ok) w_state_next = ST_WAIT_READY;
         ST_WAIT_READY: if (image_ready_in) w_state_next = (r_size == '0) ? ST_DONE : ST_STREAM;
         ST_STREAM: begin
            if (w_abort)                 w_state_next = ST_IDLE;
            else if (r_issued == r_size) w_state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_abort)                         w_state_next = ST_IDLE;
            else if (w_delivered_next == r_size) w_state_next = ST_DONE;
         end
         ST_DONE:       if (w_start_ok) w_state_next = ST_WAIT_READY;
         default:       w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_busy_next  = (w_state_next == ST_WAIT_READY) || (w_state_next == ST_STREAM) ||
                     (w_state_next == ST_DRAIN);
      w_done_next  = (w_state_next == ST_DONE);
      w_error_next = r_error;
      if (w_start_ok)   w_error_next = 1'b0;
      else if (w_abort) w_error_next = 1'b1;
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_busy  <= w_busy_next;
         r_done  <= w_done_next;
         r_error <= w_error_next;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         r_size        <= '0;
         r_issued      <= '0;
         r_delivered   <= '0;
         r_remaining   <= '0;
         r_addr        <= '0;
         r_addr_valid  <= 1'b0;
         r_outstanding <= '0;
      end else begin
         if (w_start_ok) begin
            r_size      <= image_size_in;
            r_issued    <= '0;
            r_delivered <= '0;
            r_remaining <= image_size_in;
         end else begin
            if (w_issue) r_issued <= r_issued + ADDR_WIDTH'(1);
            if (w_pop) begin
               r_delivered <= w_delivered_next;
               r_remaining <= r_remaining - ADDR_WIDTH'(1);
            end
         end
         r_addr_valid <= w_issue;
         if (w_issue) r_addr <= r_issued;
         if (w_abort) r_outstanding <= '0;
         else         r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_push);
      end
   end

   // Tracks strobes through the buffer latency; cleared so late returns are never pushed.
   always_ff @(posedge clock_in) begin
      if (reset_in || w_abort) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= r_addr_valid;
         for (int unsigned i = 1; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

`ifdef READOUT_CHECKSUM_EN
   logic [CHECKSUM_WIDTH-1:0] r_checksum;
   always_ff @(posedge clock_in) begin
      if (reset_in || w_start_ok) r_checksum <= '0;
      else if (w_pop)             r_checksum <= r_checksum + CHECKSUM_WIDTH'(w_fifo_data);
   end
   assign checksum_out = r_checksum;
`endif

   readout_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .i_clk   (clock_in),
      .i_rst   (reset_in),
      .i_flush (w_abort),
      .i_push  (w_push),
      .i_data  (bus.buffer_data_in),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_valid (w_fifo_valid),
      .o_count (w_fifo_count)
   );

   assign bus.buffer_address_out       = r_addr;
   assign bus.buffer_address_valid_out = r_addr_valid;
   assign bus.byte_out                 = w_fifo_data;
   assign bus.byte_valid_out           = w_fifo_valid;
   assign busy_out                     = r_busy;
   assign done_out                     = r_done;
   assign error_out                    = r_error;
   assign bytes_remaining_out          = r_remaining;
endmodule

// File: tb/tb_image_readout_streamer.sv
// Scoreboard bench for image_readout_streamer with a latency-accurate buffer model.
module tb_image_readout_streamer;
   localparam int unsigned AW    = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LAT   = 2;

   logic          clk = 1'b0;
   logic          reset_in = 1'b1;
   logic          start_in = 1'b0;
   logic          image_ready_in = 1'b0;
   logic [AW-1:0] image_size_in = '0;
   logic          busy_out, done_out, error_out;
   logic [AW-1:0] bytes_remaining_out;
`ifdef READOUT_CHECKSUM_EN
   logic [15:0]   checksum_out;
`endif

   image_readout_streamer_if #(.ADDR_WIDTH(AW)) bus ();

   image_readout_streamer #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
      .clock_in            (clk),
      .reset_in            (reset_in),
      .start_in            (start_in),
      .image_ready_in      (image_ready_in),
      .image_size_in       (image_size_in),
      .bus                 (bus),
      .busy_out            (busy_out),
      .done_out            (done_out),
      .error_out           (error_out),
      .bytes_remaining_out (bytes_remaining_out)
`ifdef READOUT_CHECKSUM_EN
      ,
      .checksum_out        (checksum_out)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mem [64];
   logic [7:0] sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Buffer model: data appears exactly LAT cycles after the strobe cycle.
   logic [7:0] pd [LAT];
   initial bus.buffer_data_in = 8'h00;
   initial for (int i = 0; i < LAT; i++) pd[i] = 8'h00;
   always @(negedge clk) begin
      bus.buffer_data_in = pd[LAT-1];
      for (int i = LAT - 1; i > 0; i--) pd[i] = pd[i-1];
      pd[0] = bus.buffer_address_valid_out ? mem[bus.buffer_address_out[5:0]] : 8'hEE;
   end

   // Monitor: pops the scoreboard on every handshake and checks stall hold and credit bound.
   int   hs = 0, strobes = 0, valid_cycles = 0, level = 0;
   int   valid_rise_cyc = 0, last_hs_cyc = 0;
   logic prev_stall = 1'b0, prev_valid = 1'b0;
   logic [7:0] prev_byte = 8'h00;
   logic [7:0] exp_b;
   always @(negedge clk) begin
      if (reset_in) begin
         prev_stall = 1'b0;
         prev_valid = 1'b0;
         level = 0;
      end else begin
         if (!busy_out) level = 0;
         if (prev_stall) check("stall_hold", {23'd0, bus.byte_valid_out, bus.byte_out}, {23'd0, 1'b1, prev_byte});
         if (bus.byte_valid_out && !prev_valid) valid_rise_cyc = cyc;
         if (bus.byte_valid_out) valid_cycles++;
         if (bus.buffer_address_valid_out) begin
            strobes++;
            level++;
            check("inflight_bound", 32'(level <= int'(DEPTH)), 32'd1);
         end
         if (bus.byte_valid_out && bus.byte_ready_in) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", bus.byte_out, cyc);
            end else begin
               exp_b = sb.pop_front();
               check("stream_byte", {24'd0, bus.byte_out}, {24'd0, exp_b});
            end
            hs++;
            level--;
            last_hs_cyc = cyc;
         end
         prev_stall = bus.byte_valid_out && !bus.byte_ready_in;
         prev_byte  = bus.byte_out;
         prev_valid = bus.byte_valid_out;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_image(input int size, output int start_cyc);
      for (int i = 0; i < size; i++) sb.push_back(mem[i]);
      image_size_in = AW'(size);
      start_in = 1'b1;
      start_cyc = cyc;
      tick();
      start_in = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit toggle_ready, output int done_cyc);
      int k = 0;
      while (!done_out && k < budget) begin
         if (toggle_ready) bus.byte_ready_in = ~bus.byte_ready_in;
         tick();
         k++;
      end
      check("done_reached", {31'd0, done_out}, 32'd1);
      done_cyc = cyc;
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_valid"},  {31'd0, bus.byte_valid_out}, 32'd0);
      check({name, "_strobe"}, {31'd0, bus.buffer_address_valid_out}, 32'd0);
      check({name, "_busy"},   {31'd0, busy_out}, 32'd0);
   endtask

   int t_start, t_done, base_hs, base_str, base_val, k;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'(i * 29 + 7);
      bus.byte_ready_in = 1'b1;
      repeat (3) tick();
      // Reset state
      check("rst_byte_out", {24'd0, bus.byte_out}, 32'd0);
      check("rst_addr", {16'd0, bus.buffer_address_out}, 32'd0);
      check("rst_done", {31'd0, done_out}, 32'd0);
      check("rst_error", {31'd0, error_out}, 32'd0);
      check("rst_remaining", {16'd0, bytes_remaining_out}, 32'd0);
      check_idle_outputs("rst");
`ifdef READOUT_CHECKSUM_EN
      check("rst_checksum", {16'd0, checksum_out}, 32'd0);
`endif
      reset_in = 1'b0;
      image_ready_in = 1'b1;
      tick();

      // Size 10, consumer always ready
      start_image(10, t_start);
      check("t1_busy", {31'd0, busy_out}, 32'd1);
      wait_done(100, 1'b0, t_done);
      check("t1_first_latency", 32'(valid_rise_cyc - t_start), 32'(LAT + 3));
      check("t1_one_per_cycle", 32'(last_hs_cyc - valid_rise_cyc), 32'd9);
      check("t1_done_timing", 32'(t_done), 32'(last_hs_cyc + 1));
      check("t1_remaining", {16'd0, bytes_remaining_out}, 32'd0);
      check("t1_busy_off", {31'd0, busy_out}, 32'd0);
      check("t1_sb_empty", 32'(sb.size()), 32'd0);

      // Size 20, consumer ready toggling
      start_image(20, t_start);
      wait_done(400, 1'b1, t_done);
      check("t2_sb_empty", 32'(sb.size()), 32'd0);
      check("t2_remaining", {16'd0, bytes_remaining_out}, 32'd0);
      bus.byte_ready_in = 1'b1;
      tick();

      // Size 0: straight to DONE with no reads
      base_str = strobes;
      base_val = valid_cycles;
      start_image(0, t_start);
      wait_done(20, 1'b0, t_done);
      check("t3_done_timing", 32'(t_done - t_start), 32'd2);
      repeat (3) tick();
      check("t3_no_strobes", 32'(strobes - base_str), 32'd0);
      check("t3_no_valid", 32'(valid_cycles - base_val), 32'd0);

      // Size 50, image_ready dropped after 7 handshakes
      base_hs = hs;
      start_image(50, t_start);
      k = 0;
      while (hs - base_hs < 7 && k < 100) begin tick(); k++; end
      check("t4_hs_reached", 32'(hs - base_hs >= 7), 32'd1);
      image_ready_in = 1'b0;
      tick();
      check("t4_error", {31'd0, error_out}, 32'd1);
      check("t4_done", {31'd0, done_out}, 32'd0);
      check_idle_outputs("t4_abort");
      sb.delete();
      for (int i = 0; i < 4; i++) begin
         tick();
         check_idle_outputs("t4_flushed");
         check("t4_error_hold", {31'd0, error_out}, 32'd1);
      end
      image_ready_in = 1'b1;
      start_image(3, t_start);
      check("t4_error_cleared", {31'd0, error_out}, 32'd0);
      wait_done(50, 1'b0, t_done);
      check("t4_sb_empty", 32'(sb.size()), 32'd0);
      check("t4_remaining", {16'd0, bytes_remaining_out}, 32'd0);

      // Reset mid-stream with reads in flight
      base_hs = hs;
      start_image(20, t_start);
      k = 0;
      while (hs - base_hs < 2 && k < 50) begin tick(); k++; end
      check("t5_hs_reached", 32'(hs - base_hs >= 2), 32'd1);
      reset_in = 1'b1;
      tick();
      check_idle_outputs("t5_rst");
      check("t5_done", {31'd0, done_out}, 32'd0);
      check("t5_error", {31'd0, error_out}, 32'd0);
      check("t5_remaining", {16'd0, bytes_remaining_out}, 32'd0);
      check("t5_byte_out", {24'd0, bus.byte_out}, 32'd0);
      reset_in = 1'b0;
      sb.delete();
      for (int i = 0; i < 6; i++) begin
         tick();
         check_idle_outputs("t5_late_data");
      end

      // Four-byte image 0xFF,0xFF,0x01,0x02
      mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'h01; mem[3] = 8'h02;
      start_image(4, t_start);
      wait_done(50, 1'b0, t_done);
      check("t6_sb_empty", 32'(sb.size()), 32'd0);
`ifdef READOUT_CHECKSUM_EN
      check("t6_checksum", {16'd0, checksum_out}, 32'h0201);
`endif
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
